// File: rtl/axis_rr_mux_if.sv
// rtl/axis_rr_mux_if.sv - AXI-Stream bundle carrying LANES parallel streams
//
// Signals (per lane i, data in tdata[i*WIDTH +: WIDTH]):
//   tdata   LANES*WIDTH  payload
//   tvalid  LANES        beat valid
//   tlast   LANES        end of packet
//   tready  LANES        beat accepted by the sink
// Modports: master drives tdata/tvalid/tlast, slave drives tready.
interface axis_rr_mux_if #(
    parameter int LANES = 1,
    parameter int WIDTH = 32
);
    logic [LANES*WIDTH-1:0] tdata;
    logic [LANES-1:0]       tvalid;
    logic [LANES-1:0]       tlast;
    logic [LANES-1:0]       tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_rr_mux.sv
// rtl/axis_rr_mux.sv - N-input AXI-Stream round-robin arbiter with packet lock
//
// Ports:
//   clk           clock
//   rst           synchronous reset, active high
//   s_rx          slave bundle, NUM lanes of WIDTH-bit streams
//   m_tx          master bundle, one WIDTH-bit stream to the shared sink
//   m_tx_tid      grant index tagged onto the output stream
//                 (only when AXIS_RR_MUX_TID_EN is defined)
//   grant_active  high while a stream holds the grant
//   grant_idx     currently or last granted stream
// Build option: AXIS_RR_MUX_TID_EN adds the m_tx_tid output.
module axis_rr_mux #(
    parameter int NUM       = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BEATS = 0,
    parameter int IDX_BITS  = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                clk,
    input  logic                rst,
    axis_rr_mux_if.slave        s_rx,
    axis_rr_mux_if.master       m_tx,
`ifdef AXIS_RR_MUX_TID_EN
    output logic [IDX_BITS-1:0] m_tx_tid,
`endif
    output logic                grant_active,
    output logic [IDX_BITS-1:0] grant_idx
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                state_q;
    logic [IDX_BITS-1:0]   ptr_q;
    logic [IDX_BITS-1:0]   grant_idx_q;
    logic                  grant_active_q;

    logic                  live;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  force_rel;
    logic                  xfer;
    logic                  release_now;
    logic                  found;
    logic [IDX_BITS-1:0]   winner;
    logic [IDX_BITS-1:0]   ptr_d;

    // Gating with rst makes a mid-packet reset drop the grant in the same
    // cycle, so no beat can be accepted while reset is asserted.
    assign live      = (state_q == BUSY) && !rst;
    assign sel_valid = s_rx.tvalid[grant_idx_q];
    assign sel_last  = s_rx.tlast[grant_idx_q];

    assign m_tx.tdata  = s_rx.tdata[int'(grant_idx_q)*WIDTH +: WIDTH];
    assign m_tx.tvalid = live && sel_valid;
    assign m_tx.tlast  = m_tx.tvalid && (sel_last || force_rel);
    assign s_rx.tready = live ? (NUM'(m_tx.tready) << grant_idx_q) : '0;

    assign xfer        = m_tx.tvalid && m_tx.tready;
    assign release_now = xfer && (sel_last || force_rel);

`ifdef AXIS_RR_MUX_TID_EN
    assign m_tx_tid = grant_idx_q;
`endif

    assign grant_active = grant_active_q && !rst;
    assign grant_idx    = grant_idx_q;

    // The counter only exists when a beat limit is configured; force_rel
    // flags the beat that will end the grant.
    generate
        if (MAX_BEATS != 0) begin : g_cnt
            localparam int CNT_W = $clog2(MAX_BEATS + 1);
            logic [CNT_W-1:0] beat_cnt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    beat_cnt_q <= '0;
                end else if (state_q == IDLE) begin
                    beat_cnt_q <= '0;
                end else if (xfer && beat_cnt_q != CNT_W'(MAX_BEATS)) begin
                    beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                end
            end

            assign force_rel = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
        end else begin : g_nocnt
            assign force_rel = 1'b0;
        end
    endgenerate

    // First valid stream at or after ptr, wrapping; ptr points one past the
    // last served stream so that stream ends up with lowest priority.
    always_comb begin
        int j;
        found  = 1'b0;
        winner = ptr_q;
        j      = 0;
        for (int k = 0; k < NUM; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM) begin
                j = j - NUM;
            end
            if (!found && s_rx.tvalid[j]) begin
                found  = 1'b1;
                winner = IDX_BITS'(j);
            end
        end
    end

    assign ptr_d = (grant_idx_q == IDX_BITS'(NUM - 1)) ? '0 : grant_idx_q + IDX_BITS'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            grant_idx_q    <= '0;
            grant_active_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_idx_q    <= winner;
                        grant_active_q <= 1'b1;
                        state_q        <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        ptr_q          <= ptr_d;
                        grant_active_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    grant_active_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_mux.sv
// tb/tb_axis_rr_mux.sv - directed table-driven bench for axis_rr_mux
module tb_axis_rr_mux;
    localparam int NUM = 4;
    localparam int W   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [NUM-1:0]     tvalid_drv;
    logic [NUM-1:0]     tlast_drv;
    logic [NUM*W-1:0]   tdata_drv;
    logic               m_rdy;
    logic               use4;

    axis_rr_mux_if #(.LANES(NUM), .WIDTH(W)) rx0();
    axis_rr_mux_if #(.LANES(1),   .WIDTH(W)) tx0();
    axis_rr_mux_if #(.LANES(NUM), .WIDTH(W)) rx4();
    axis_rr_mux_if #(.LANES(1),   .WIDTH(W)) tx4();

    assign rx0.tdata  = tdata_drv;
    assign rx0.tvalid = tvalid_drv;
    assign rx0.tlast  = tlast_drv;
    assign tx0.tready = m_rdy;
    assign rx4.tdata  = tdata_drv;
    assign rx4.tvalid = tvalid_drv;
    assign rx4.tlast  = tlast_drv;
    assign tx4.tready = m_rdy;

    logic       ga0, ga4;
    logic [1:0] gi0, gi4;
`ifdef AXIS_RR_MUX_TID_EN
    logic [1:0] tid0, tid4;
`endif

    axis_rr_mux #(.NUM(NUM), .WIDTH(W), .MAX_BEATS(0)) dut0 (
        .clk(clk), .rst(rst), .s_rx(rx0), .m_tx(tx0),
`ifdef AXIS_RR_MUX_TID_EN
        .m_tx_tid(tid0),
`endif
        .grant_active(ga0), .grant_idx(gi0)
    );

    axis_rr_mux #(.NUM(NUM), .WIDTH(W), .MAX_BEATS(4)) dut4 (
        .clk(clk), .rst(rst), .s_rx(rx4), .m_tx(tx4),
`ifdef AXIS_RR_MUX_TID_EN
        .m_tx_tid(tid4),
`endif
        .grant_active(ga4), .grant_idx(gi4)
    );

    logic           obs_ga, obs_mv, obs_ml;
    logic [1:0]     obs_gi;
    logic [NUM-1:0] obs_srdy;
    logic [W-1:0]   obs_md;
    assign obs_ga   = use4 ? ga4 : ga0;
    assign obs_gi   = use4 ? gi4 : gi0;
    assign obs_mv   = use4 ? tx4.tvalid[0] : tx0.tvalid[0];
    assign obs_ml   = use4 ? tx4.tlast[0]  : tx0.tlast[0];
    assign obs_srdy = use4 ? rx4.tready : rx0.tready;
    assign obs_md   = use4 ? tx4.tdata  : tx0.tdata;

    int n_cmp = 0;
    int n_bad = 0;

    // Source model: stream i sends beats {i, beat} and raises tlast on beat len-1.
    int             beat [NUM];
    int             len  [NUM];
    logic [NUM-1:0] en;

    typedef struct {
        bit       rst;
        bit [3:0] en;
        bit       ga;
        bit [1:0] gi;
        bit       mv;
        bit       ml;
        bit [3:0] srdy;
        int       bt;
    } vec_t;
    vec_t vt[$];

    function automatic void v(bit r, bit [3:0] e, bit ga, bit [1:0] gi, bit mv, bit ml,
                              bit [3:0] sr, int bt);
        vec_t x;
        x.rst = r; x.en = e; x.ga = ga; x.gi = gi; x.mv = mv; x.ml = ml; x.srdy = sr; x.bt = bt;
        vt.push_back(x);
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    task automatic src_clear();
        for (int i = 0; i < NUM; i++) begin
            beat[i] = 0;
            len[i]  = 3;
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < NUM; i++) begin
            tvalid_drv[i]       = en[i];
            tdata_drv[i*W +: W] = {8'(i), 24'(beat[i])};
            tlast_drv[i]        = (beat[i] == len[i] - 1);
        end
    endtask

    // Called at the negedge after checks: advance sources that handshook.
    task automatic end_cycle();
        logic [NUM-1:0] xf;
        xf = obs_srdy & tvalid_drv;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM; i++) begin
            if (xf[i]) beat[i] = tlast_drv[i] ? 0 : beat[i] + 1;
        end
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        en  = '0;
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_vecs(string tag);
        foreach (vt[k]) begin
            rst   = vt[k].rst;
            en    = vt[k].en;
            m_rdy = 1'b1;
            drive_src();
            @(negedge clk);
            chk({tag, " grant_active"}, k, 32'(obs_ga),   32'(vt[k].ga));
            chk({tag, " grant_idx"},    k, 32'(obs_gi),   32'(vt[k].gi));
            chk({tag, " m_tvalid"},     k, 32'(obs_mv),   32'(vt[k].mv));
            chk({tag, " m_tlast"},      k, 32'(obs_ml),   32'(vt[k].ml));
            chk({tag, " s_tready"},     k, 32'(obs_srdy), 32'(vt[k].srdy));
            if (vt[k].mv) begin
                chk({tag, " m_tdata"}, k, obs_md, {8'(vt[k].gi), 24'(vt[k].bt)});
`ifdef AXIS_RR_MUX_TID_EN
                chk({tag, " m_tid"}, k, 32'(use4 ? tid4 : tid0), 32'(vt[k].gi));
`endif
            end
            end_cycle();
        end
        vt.delete();
    endtask

    initial begin
        int exp_beat;
        rst   = 1'b1;
        en    = '0;
        m_rdy = 1'b1;
        use4  = 1'b0;
        src_clear();
        drive_src();
        repeat (3) @(posedge clk);
        #1;

        // Reset with all streams valid, then full rotation of 3-beat packets.
        src_clear();
        v(1,4'hF,0,0,0,0,4'h0,0); v(1,4'hF,0,0,0,0,4'h0,0);
        v(0,4'hF,0,0,0,0,4'h0,0);
        v(0,4'hF,1,0,1,0,4'h1,0); v(0,4'hF,1,0,1,0,4'h1,1); v(0,4'hF,1,0,1,1,4'h1,2);
        v(0,4'hF,0,0,0,0,4'h0,0);
        v(0,4'hF,1,1,1,0,4'h2,0); v(0,4'hF,1,1,1,0,4'h2,1); v(0,4'hF,1,1,1,1,4'h2,2);
        v(0,4'hF,0,1,0,0,4'h0,0);
        v(0,4'hF,1,2,1,0,4'h4,0); v(0,4'hF,1,2,1,0,4'h4,1); v(0,4'hF,1,2,1,1,4'h4,2);
        v(0,4'hF,0,2,0,0,4'h0,0);
        v(0,4'hF,1,3,1,0,4'h8,0); v(0,4'hF,1,3,1,0,4'h8,1); v(0,4'hF,1,3,1,1,4'h8,2);
        v(0,4'hF,0,3,0,0,4'h0,0);
        v(0,4'hF,1,0,1,0,4'h1,0);
        run_vecs("rotate");

        // Reset in the middle of a stream-1 packet; ptr must restart at 0.
        hard_reset();
        src_clear();
        len[1] = 5; len[2] = 1;
        v(0,4'b0100,0,0,0,0,4'h0,0);
        v(0,4'b0110,1,2,1,1,4'h4,0);
        v(0,4'b0010,0,2,0,0,4'h0,0);
        v(0,4'b0010,1,1,1,0,4'h2,0); v(0,4'b0010,1,1,1,0,4'h2,1);
        v(1,4'b1111,0,1,0,0,4'h0,0);
        v(0,4'b1111,0,0,0,0,4'h0,0);
        v(0,4'b1111,1,0,1,0,4'h1,0);
        run_vecs("midreset");

        // Beat limit of 4: long stream-1 packet is cut, others get their turn.
        use4 = 1'b1;
        hard_reset();
        src_clear();
        len[1] = 10; len[0] = 2; len[3] = 2;
        v(0,4'b0010,0,0,0,0,4'h0,0);
        v(0,4'b1011,1,1,1,0,4'h2,0); v(0,4'b1011,1,1,1,0,4'h2,1);
        v(0,4'b1011,1,1,1,0,4'h2,2); v(0,4'b1011,1,1,1,1,4'h2,3);
        v(0,4'b1011,0,1,0,0,4'h0,0);
        v(0,4'b1011,1,3,1,0,4'h8,0); v(0,4'b1011,1,3,1,1,4'h8,1);
        v(0,4'b1011,0,3,0,0,4'h0,0);
        v(0,4'b1011,1,0,1,0,4'h1,0); v(0,4'b1011,1,0,1,1,4'h1,1);
        v(0,4'b1011,0,0,0,0,4'h0,0);
        v(0,4'b1011,1,1,1,0,4'h2,4); v(0,4'b1011,1,1,1,0,4'h2,5);
        v(0,4'b1011,1,1,1,0,4'h2,6); v(0,4'b1011,1,1,1,1,4'h2,7);
        v(0,4'b1011,0,1,0,0,4'h0,0);
        run_vecs("maxbeats");

        // Stream 2 with sink ready toggling: beats in order, none lost or repeated.
        use4 = 1'b0;
        hard_reset();
        src_clear();
        len[2]   = 6;
        exp_beat = 0;
        for (int cyc = 0; cyc < 40 && exp_beat < 6; cyc++) begin
            en    = 4'b0100;
            m_rdy = cyc[0];
            drive_src();
            @(negedge clk);
            if (obs_ga) chk("toggle s_tready", cyc, 32'(obs_srdy), 32'({m_rdy, 2'b00}));
            if (obs_mv && m_rdy) begin
                chk("toggle m_tdata", cyc, obs_md, {8'd2, 24'(exp_beat)});
                chk("toggle m_tlast", cyc, 32'(obs_ml), 32'(exp_beat == 5));
                exp_beat++;
            end
            end_cycle();
        end
        chk("toggle beats_received", 0, 32'(exp_beat), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
